// File: rtl/spi_master_param.sv
// Parametrised SPI master with a control register and an in-place exchange
// buffer. Each word in buf[0..n_tx_end] is shifted out MSB-first and
// replaced with the word shifted in from miso_i.
module spi_master_param #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 256,
  parameter int N_CS    = 1,
  parameter int CLK_DIV = 4,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              reg_sel_i,
  input  logic              wr_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       in_i,
  output logic [31:0]       out_o,
  input  logic              miso_i,
  output logic              mosi_o,
  output logic              sclk_o,
  output logic [N_CS-1:0]   cs_n_o,
  output logic              busy_o,
  output logic              tx_done_o
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGE_W = $clog2(2 * DATA_W);

  typedef enum logic [2:0] {IDLE, SETUP, TRANSFER, STORE, FINISH} state_t;

  // Writable part of the control register, laid out exactly as bits [15:0].
  typedef struct packed {
    logic [7:0] n_tx_end;
    logic [1:0] cs_sel;
    logic       cpha;
    logic       cpol;
    logic       all_zeros;
    logic       all_ones;
    logic       cs_ctrl;
    logic       send;
  } ctrl_t;

  state_t            state_q, state_d;
  ctrl_t             ctrl_q;
  logic [8:0]        rx_cnt_q;
  logic [7:0]        k_q;
  logic [7:0]        k_next;
  logic [DIV_W-1:0]  div_cnt_q;
  logic [EDGE_W-1:0] edge_cnt_q;
  logic [DATA_W-1:0] tx_sh_q;
  logic [DATA_W-1:0] rx_sh_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              host_wr_ctrl;
  logic              host_wr_buf;
  logic              start;
  logic              div_done;
  logic              last_edge;
  logic              last_word;
  logic              sample_edge;
  logic [DATA_W-1:0] word_first;
  logic [DATA_W-1:0] word_next;
  logic [N_CS-1:0]   cs_pattern;
  logic [31:0]       ctrl_word;
  logic              unused_in;

  // Fixed patterns override buffer data; all_ones wins over all_zeros.
  function automatic logic [DATA_W-1:0] tx_word(input ctrl_t c, input logic [DATA_W-1:0] raw);
    if (c.all_ones)  return '1;
    if (c.all_zeros) return '0;
    return raw;
  endfunction

  // Host accesses are locked out for the whole transaction.
  assign host_wr_ctrl = wr_i && !reg_sel_i && !busy_o;
  assign host_wr_buf  = wr_i &&  reg_sel_i && !busy_o;
  // send is accepted on the write itself, so fields written alongside it apply.
  assign start        = host_wr_ctrl && in_i[0];

  assign div_done    = (div_cnt_q == DIV_W'(CLK_DIV - 1));
  assign last_edge   = (edge_cnt_q == EDGE_W'(2 * DATA_W - 1));
  assign last_word   = (k_q == ctrl_q.n_tx_end);
  // Even edges are leading; cpha=0 samples on leading, cpha=1 on trailing.
  assign sample_edge = (~edge_cnt_q[0]) != ctrl_q.cpha;
  assign k_next      = k_q + 8'd1;

  assign word_first = tx_word(ctrl_q, mem[0]);
  assign word_next  = tx_word(ctrl_q, mem[k_next[ADDR_W-1:0]]);
  assign ctrl_word  = {7'd0, rx_cnt_q, ctrl_q};
  assign unused_in  = ^in_i[31:16];

  // Chip-select decode: idle level follows cs_ctrl, asserted outside IDLE.
  always_comb begin
    cs_pattern = '1;
    for (int i = 0; i < N_CS; i++) begin
      if (int'(ctrl_q.cs_sel) == i) begin
        cs_pattern[i] = (state_q == IDLE) ? ~ctrl_q.cs_ctrl : 1'b0;
      end
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge reset_i) begin
    // NOTE: every flop is updated with <= so all registers sample the same
    // pre-edge values; a blocking '=' here would create order-dependent races.
    if (!reset_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assigned first so every path drives state_d; without it
    // the unlisted paths would infer a latch.
    state_d = state_q;
    case (state_q)
      IDLE:     if (start) state_d = SETUP;
      SETUP:    if (div_done) state_d = TRANSFER;
      TRANSFER: if (div_done && last_edge) state_d = STORE;
      STORE:    state_d = last_word ? FINISH : TRANSFER;
      FINISH:   if (div_done) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Control register, counters, shift registers and SPI pins.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      ctrl_q     <= '0;
      rx_cnt_q   <= '0;
      k_q        <= '0;
      div_cnt_q  <= '0;
      edge_cnt_q <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      sclk_o     <= 1'b0;
      mosi_o     <= 1'b0;
      cs_n_o     <= '1;
      busy_o     <= 1'b0;
      tx_done_o  <= 1'b0;
    end else begin
      tx_done_o <= 1'b0;
      cs_n_o    <= cs_pattern;

      if (state_q inside {IDLE, STORE} || div_done) div_cnt_q <= '0;
      else                                         div_cnt_q <= div_cnt_q + DIV_W'(1);

      if (host_wr_ctrl) ctrl_q <= ctrl_t'(in_i[15:0]);

      case (state_q)
        IDLE: begin
          sclk_o <= ctrl_q.cpol;
          if (start) begin
            busy_o   <= 1'b1;
            rx_cnt_q <= '0;
            k_q      <= '0;
          end
        end
        SETUP: begin
          sclk_o     <= ctrl_q.cpol;
          edge_cnt_q <= '0;
          if (div_cnt_q == '0) begin
            tx_sh_q <= word_first;
            if (!ctrl_q.cpha) mosi_o <= word_first[DATA_W-1];
          end
        end
        TRANSFER: begin
          if (div_done) begin
            sclk_o     <= ~sclk_o;
            edge_cnt_q <= last_edge ? '0 : edge_cnt_q + EDGE_W'(1);
            if (sample_edge) begin
              rx_sh_q <= {rx_sh_q[DATA_W-2:0], miso_i};
            end else begin
              // cpha=1 presents the current MSB; cpha=0 moves to the next bit.
              tx_sh_q <= tx_sh_q << 1;
              mosi_o  <= ctrl_q.cpha ? tx_sh_q[DATA_W-1] : tx_sh_q[DATA_W-2];
            end
          end
        end
        STORE: begin
          rx_cnt_q <= rx_cnt_q + 9'd1;
          if (!last_word) begin
            k_q     <= k_next;
            tx_sh_q <= word_next;
            if (!ctrl_q.cpha) mosi_o <= word_next[DATA_W-1];
          end
        end
        FINISH: begin
          if (div_done) begin
            ctrl_q.send <= 1'b0;
            tx_done_o   <= 1'b1;
            busy_o      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Exchange buffer: received words overwrite their slot, host writes when idle.
  always_ff @(posedge clk_i) begin
    // NOTE: the buffer is deliberately left out of reset so it maps onto plain
    // RAM; its contents survive reset.
    if (state_q == STORE)  mem[k_q[ADDR_W-1:0]] <= rx_sh_q;
    else if (host_wr_buf)  mem[addr_i]          <= in_i[DATA_W-1:0];
  end

  // Registered read port, refreshed every cycle.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i)       out_o <= '0;
    else if (reg_sel_i) out_o <= 32'(mem[addr_i]);
    else                out_o <= ctrl_word;
  end

endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param: loopback, fixed patterns, mode 3,
// multi chip-select, busy lockout, mid-transfer reset and full-depth run.
module tb_spi_master_param;

  localparam int DATA_W  = 8;
  localparam int DEPTH   = 256;
  localparam int N_CS    = 4;
  localparam int CLK_DIV = 2;

  logic            clk = 1'b0;
  logic            reset_n = 1'b1;
  logic            reg_sel = 1'b0;
  logic            wr = 1'b0;
  logic [7:0]      addr = '0;
  logic [31:0]     wdata = '0;
  logic [31:0]     rdata;
  logic            miso, mosi, sclk, busy, tx_done;
  logic [N_CS-1:0] cs_n;

  logic            lb = 1'b0;
  logic            miso_drv = 1'b0;
  logic            slave_en = 1'b0;
  logic [7:0]      slave_sh = '0;

  int n_cmp = 0;
  int n_bad = 0;

  assign miso = lb ? mosi : miso_drv;

  always #5 clk = ~clk;

  spi_master_param #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .N_CS   (N_CS),
    .CLK_DIV(CLK_DIV)
  ) dut (
    .clk_i    (clk),
    .reset_i  (reset_n),
    .reg_sel_i(reg_sel),
    .wr_i     (wr),
    .addr_i   (addr),
    .in_i     (wdata),
    .out_o    (rdata),
    .miso_i   (miso),
    .mosi_o   (mosi),
    .sclk_o   (sclk),
    .cs_n_o   (cs_n),
    .busy_o   (busy),
    .tx_done_o(tx_done)
  );

  task automatic host_write(input logic sel, input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    reg_sel = sel; addr = a; wdata = d; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic host_read(input logic sel, input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    reg_sel = sel; addr = a; wr = 1'b0;
    @(negedge clk);
    d = rdata;
  endtask

  // Writes ctrl_val (with send) and watches the bus until tx_done_o + 4 cycles.
  task automatic run_txn(input logic [31:0] ctrl_val, input int limit, input bit busy_wr,
                         output int done_cyc, output int pulses, output int rises,
                         output logic [63:0] bits, output logic [N_CS-1:0] cs_mid);
    logic prev;
    int   cyc;
    done_cyc = -1; pulses = 0; rises = 0; bits = '0; cs_mid = '1;
    host_write(1'b0, 8'd0, ctrl_val);
    prev = sclk;
    cyc  = 0;
    while (cyc < limit) begin
      if (sclk && !prev) begin
        rises++;
        bits = {bits[62:0], mosi};
        if (rises == 1) cs_mid = cs_n;
      end
      if (!sclk && prev && slave_en) begin
        miso_drv = slave_sh[7];
        slave_sh = slave_sh << 1;
      end
      prev = sclk;
      if (tx_done) begin
        pulses++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 4) break;
      if (busy_wr) begin
        case (cyc)
          5:       begin reg_sel = 1'b0; wdata = 32'h0000_FF3E; wr = 1'b1; end
          34:      begin reg_sel = 1'b1; addr = 8'd5; wdata = 32'h0000_00EE; wr = 1'b1; end
          default: wr = 1'b0;
        endcase
      end
      @(negedge clk);
      cyc++;
    end
    wr = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (sclk !== 1'b0)    begin n_bad++; $display("FAIL rst_sclk: got %b expected 0", sclk); end
    n_cmp++; if (mosi !== 1'b0)    begin n_bad++; $display("FAIL rst_mosi: got %b expected 0", mosi); end
    n_cmp++; if (cs_n !== 4'hF)    begin n_bad++; $display("FAIL rst_cs_n: got %h expected f", cs_n); end
    n_cmp++; if (busy !== 1'b0)    begin n_bad++; $display("FAIL rst_busy: got %b expected 0", busy); end
    n_cmp++; if (tx_done !== 1'b0) begin n_bad++; $display("FAIL rst_tx_done: got %b expected 0", tx_done); end
    n_cmp++; if (rdata !== 32'd0)  begin n_bad++; $display("FAIL rst_out: got %h expected 0", rdata); end
    reset_n = 1'b1;
    host_read(1'b0, 8'd0, d);
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL rst_ctrl: got %h expected 0", d); end
  endtask

  task automatic test_loopback_mode0();
    int done_cyc, pulses, rises; logic [63:0] bits; logic [N_CS-1:0] cs_mid; logic [31:0] d;
    host_write(1'b1, 8'd0, 32'hA5);
    host_write(1'b1, 8'd1, 32'h3C);
    lb = 1'b1;
    run_txn(32'h0000_0101, 200, 1'b0, done_cyc, pulses, rises, bits, cs_mid);
    n_cmp++; if (done_cyc !== 70)      begin n_bad++; $display("FAIL lb_done_cycle: got %0d expected 70", done_cyc); end
    n_cmp++; if (pulses !== 1)         begin n_bad++; $display("FAIL lb_pulses: got %0d expected 1", pulses); end
    n_cmp++; if (rises !== 16)         begin n_bad++; $display("FAIL lb_rises: got %0d expected 16", rises); end
    n_cmp++; if (bits[15:0] !== 16'hA53C) begin n_bad++; $display("FAIL lb_mosi_bits: got %h expected a53c", bits[15:0]); end
    n_cmp++; if (cs_mid !== 4'b1110)   begin n_bad++; $display("FAIL lb_cs_mid: got %b expected 1110", cs_mid); end
    n_cmp++; if (cs_n !== 4'b1111)     begin n_bad++; $display("FAIL lb_cs_after: got %b expected 1111", cs_n); end
    n_cmp++; if (busy !== 1'b0)        begin n_bad++; $display("FAIL lb_busy_after: got %b expected 0", busy); end
    host_read(1'b1, 8'd0, d);
    n_cmp++; if (d !== 32'hA5) begin n_bad++; $display("FAIL lb_buf0: got %h expected a5", d); end
    host_read(1'b1, 8'd1, d);
    n_cmp++; if (d !== 32'h3C) begin n_bad++; $display("FAIL lb_buf1: got %h expected 3c", d); end
    host_read(1'b0, 8'd0, d);
    n_cmp++; if (d !== 32'h0002_0100) begin n_bad++; $display("FAIL lb_ctrl: got %h expected 00020100", d); end
  endtask

  task automatic test_all_ones();
    int done_cyc, pulses, rises; logic [63:0] bits; logic [N_CS-1:0] cs_mid; logic [31:0] d;
    lb = 1'b0; miso_drv = 1'b0;
    host_write(1'b1, 8'd0, 32'h5A);
    run_txn(32'h0000_0005, 200, 1'b0, done_cyc, pulses, rises, bits, cs_mid);
    n_cmp++; if (done_cyc !== 37)       begin n_bad++; $display("FAIL ones_done_cycle: got %0d expected 37", done_cyc); end
    n_cmp++; if (rises !== 8)           begin n_bad++; $display("FAIL ones_rises: got %0d expected 8", rises); end
    n_cmp++; if (bits[7:0] !== 8'hFF)   begin n_bad++; $display("FAIL ones_mosi: got %h expected ff", bits[7:0]); end
    host_read(1'b1, 8'd0, d);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL ones_buf0: got %h expected 0", d); end
    host_write(1'b1, 8'd0, 32'h5A);
    run_txn(32'h0000_000D, 200, 1'b0, done_cyc, pulses, rises, bits, cs_mid);
    n_cmp++; if (bits[7:0] !== 8'hFF)   begin n_bad++; $display("FAIL ones_zeros_mosi: got %h expected ff", bits[7:0]); end
    host_read(1'b1, 8'd0, d);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL ones_zeros_buf0: got %h expected 0", d); end
    host_read(1'b0, 8'd0, d);
    n_cmp++; if (d !== 32'h0001_000C) begin n_bad++; $display("FAIL ones_ctrl: got %h expected 0001000c", d); end
  endtask

  task automatic test_mode3();
    int done_cyc, pulses, rises; logic [63:0] bits; logic [N_CS-1:0] cs_mid; logic [31:0] d;
    lb = 1'b0; miso_drv = 1'b0;
    host_write(1'b0, 8'd0, 32'h0000_0030);
    @(negedge clk);
    n_cmp++; if (sclk !== 1'b1) begin n_bad++; $display("FAIL m3_sclk_idle: got %b expected 1", sclk); end
    slave_sh = 8'h81; slave_en = 1'b1;
    run_txn(32'h0000_0031, 200, 1'b0, done_cyc, pulses, rises, bits, cs_mid);
    slave_en = 1'b0;
    n_cmp++; if (pulses !== 1)  begin n_bad++; $display("FAIL m3_pulses: got %0d expected 1", pulses); end
    n_cmp++; if (rises !== 8)   begin n_bad++; $display("FAIL m3_rises: got %0d expected 8", rises); end
    n_cmp++; if (sclk !== 1'b1) begin n_bad++; $display("FAIL m3_sclk_after: got %b expected 1", sclk); end
    host_read(1'b1, 8'd0, d);
    n_cmp++; if (d !== 32'h81) begin n_bad++; $display("FAIL m3_buf0: got %h expected 81", d); end
    host_write(1'b0, 8'd0, 32'h0);
  endtask

  task automatic test_cs();
    int done_cyc, pulses, rises; logic [63:0] bits; logic [N_CS-1:0] cs_mid; logic [31:0] d;
    lb = 1'b1;
    host_write(1'b0, 8'd0, 32'h0000_0080);
    run_txn(32'h0000_0081, 200, 1'b0, done_cyc, pulses, rises, bits, cs_mid);
    n_cmp++; if (cs_mid !== 4'b1011) begin n_bad++; $display("FAIL cs2_mid: got %b expected 1011", cs_mid); end
    n_cmp++; if (cs_n !== 4'b1111)   begin n_bad++; $display("FAIL cs2_after: got %b expected 1111", cs_n); end
    host_write(1'b0, 8'd0, 32'h0000_0082);
    @(negedge clk);
    n_cmp++; if (cs_n !== 4'b1011)   begin n_bad++; $display("FAIL cs2_hold_idle: got %b expected 1011", cs_n); end
    run_txn(32'h0000_0083, 200, 1'b0, done_cyc, pulses, rises, bits, cs_mid);
    n_cmp++; if (cs_mid !== 4'b1011) begin n_bad++; $display("FAIL cs2_hold_mid: got %b expected 1011", cs_mid); end
    n_cmp++; if (cs_n !== 4'b1011)   begin n_bad++; $display("FAIL cs2_hold_after: got %b expected 1011", cs_n); end
    host_read(1'b0, 8'd0, d);
    n_cmp++; if (d !== 32'h0001_0082) begin n_bad++; $display("FAIL cs2_ctrl: got %h expected 00010082", d); end
    host_write(1'b0, 8'd0, 32'h0);
  endtask

  task automatic test_busy_writes();
    int done_cyc, pulses, rises; logic [63:0] bits; logic [N_CS-1:0] cs_mid; logic [31:0] d;
    host_write(1'b1, 8'd0, 32'h11);
    host_write(1'b1, 8'd1, 32'h22);
    host_write(1'b1, 8'd5, 32'h55);
    lb = 1'b1;
    run_txn(32'h0000_0101, 200, 1'b1, done_cyc, pulses, rises, bits, cs_mid);
    n_cmp++; if (done_cyc !== 70) begin n_bad++; $display("FAIL busy_done_cycle: got %0d expected 70", done_cyc); end
    host_read(1'b0, 8'd0, d);
    n_cmp++; if (d !== 32'h0002_0100) begin n_bad++; $display("FAIL busy_ctrl: got %h expected 00020100", d); end
    host_read(1'b1, 8'd5, d);
    n_cmp++; if (d !== 32'h55) begin n_bad++; $display("FAIL busy_buf5: got %h expected 55", d); end
    host_read(1'b1, 8'd0, d);
    n_cmp++; if (d !== 32'h11) begin n_bad++; $display("FAIL busy_buf0: got %h expected 11", d); end
    host_read(1'b1, 8'd1, d);
    n_cmp++; if (d !== 32'h22) begin n_bad++; $display("FAIL busy_buf1: got %h expected 22", d); end
  endtask

  task automatic test_reset_mid();
    logic prev; int rises, cyc, pulses, busy_seen; logic [31:0] d;
    host_write(1'b1, 8'd0, 32'hC3);
    lb = 1'b1;
    host_write(1'b0, 8'd0, 32'h0000_0001);
    prev = sclk; rises = 0; cyc = 0;
    while (rises < 4 && cyc < 100) begin
      @(negedge clk); cyc++;
      if (sclk && !prev) rises++;
      prev = sclk;
    end
    n_cmp++; if (rises !== 4)   begin n_bad++; $display("FAIL rmid_reach_bit3: got %0d expected 4", rises); end
    n_cmp++; if (sclk !== 1'b1) begin n_bad++; $display("FAIL rmid_sclk_pre: got %b expected 1", sclk); end
    reset_n = 1'b0;
    #1;
    n_cmp++; if (sclk !== 1'b0)  begin n_bad++; $display("FAIL rmid_sclk: got %b expected 0", sclk); end
    n_cmp++; if (cs_n !== 4'hF)  begin n_bad++; $display("FAIL rmid_cs_n: got %h expected f", cs_n); end
    n_cmp++; if (busy !== 1'b0)  begin n_bad++; $display("FAIL rmid_busy: got %b expected 0", busy); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    pulses = 0; busy_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (tx_done) pulses++;
      if (busy) busy_seen++;
    end
    n_cmp++; if (pulses !== 0)    begin n_bad++; $display("FAIL rmid_no_done: got %0d expected 0", pulses); end
    n_cmp++; if (busy_seen !== 0) begin n_bad++; $display("FAIL rmid_no_busy: got %0d expected 0", busy_seen); end
    host_read(1'b0, 8'd0, d);
    n_cmp++; if (d !== 32'h0)  begin n_bad++; $display("FAIL rmid_ctrl: got %h expected 0", d); end
    host_read(1'b1, 8'd0, d);
    n_cmp++; if (d !== 32'hC3) begin n_bad++; $display("FAIL rmid_buf0_kept: got %h expected c3", d); end
  endtask

  task automatic test_full_depth();
    int done_cyc, pulses, rises; logic [63:0] bits; logic [N_CS-1:0] cs_mid; logic [31:0] d;
    for (int i = 0; i < DEPTH; i++) host_write(1'b1, 8'(i), 32'(i));
    lb = 1'b1;
    run_txn(32'h0000_FF01, 9000, 1'b0, done_cyc, pulses, rises, bits, cs_mid);
    n_cmp++; if (done_cyc !== 8452) begin n_bad++; $display("FAIL full_done_cycle: got %0d expected 8452", done_cyc); end
    n_cmp++; if (pulses !== 1)      begin n_bad++; $display("FAIL full_pulses: got %0d expected 1", pulses); end
    n_cmp++; if (rises !== 2048)    begin n_bad++; $display("FAIL full_rises: got %0d expected 2048", rises); end
    host_read(1'b0, 8'd0, d);
    n_cmp++; if (d !== 32'h0100_FF00) begin n_bad++; $display("FAIL full_ctrl: got %h expected 0100ff00", d); end
    for (int i = 0; i < DEPTH; i++) begin
      host_read(1'b1, 8'(i), d);
      n_cmp++; if (d !== 32'(i)) begin n_bad++; $display("FAIL full_buf[%0d]: got %h expected %h", i, d, 32'(i)); end
    end
  endtask

  initial begin
    test_reset();
    test_loopback_mode0();
    test_all_ones();
    test_mode3();
    test_cs();
    test_busy_writes();
    test_reset_mid();
    test_full_depth();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
